// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters advanced by a pixel strobe, producing
// registered sync, pixel position, active flag, frame-end pulse and frame count.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_stb,
  output logic       o_hs,
  output logic       o_vs,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_active,
  output logic       o_animate,
  output logic [7:0] o_frame
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_END   = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_END   = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  if (H_ACTIVE > 1024 || V_ACTIVE > 512 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_cfg
    $fatal(1, "vga_timing_gen: timing parameters exceed counter/output widths");
  end

  typedef enum logic [1:0] {HS_ACT, HS_FRONT, HS_SYNC, HS_BACK} h_state_e;
  typedef enum logic [1:0] {VS_ACT, VS_FRONT, VS_SYNC, VS_BACK} v_state_e;

  h_state_e   h_state_q, h_state_d;
  v_state_e   v_state_q, v_state_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [7:0] frame_q, frame_d;
  logic       line_adv;
  logic       animate_d;
  logic       hs_q, vs_q, active_q, animate_q;
  logic [9:0] x_q;
  logic [8:0] y_q;

  // Next counter/state values; identical to current ones when no strobe.
  always_comb begin
    h_cnt_d   = h_cnt_q;
    h_state_d = h_state_q;
    v_cnt_d   = v_cnt_q;
    v_state_d = v_state_q;
    frame_d   = frame_q;
    line_adv  = 1'b0;
    if (i_pix_stb) begin
      line_adv = (h_cnt_q == H_LAST);
      h_cnt_d  = line_adv ? 10'd0 : h_cnt_q + 10'd1;
      case (h_state_q)
        HS_ACT:   if (h_cnt_q == H_ACT_END)  h_state_d = HS_FRONT;
        HS_FRONT: if (h_cnt_q == H_FP_END)   h_state_d = HS_SYNC;
        HS_SYNC:  if (h_cnt_q == H_SYNC_END) h_state_d = HS_BACK;
        HS_BACK:  if (line_adv)              h_state_d = HS_ACT;
        default:                             h_state_d = HS_ACT;
      endcase
      if (line_adv) begin
        v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        if (v_cnt_q == V_LAST) frame_d = frame_q + 8'd1;
        case (v_state_q)
          VS_ACT:   if (v_cnt_q == V_ACT_END)  v_state_d = VS_FRONT;
          VS_FRONT: if (v_cnt_q == V_FP_END)   v_state_d = VS_SYNC;
          VS_SYNC:  if (v_cnt_q == V_SYNC_END) v_state_d = VS_BACK;
          VS_BACK:  if (v_cnt_q == V_LAST)     v_state_d = VS_ACT;
          default:                             v_state_d = VS_ACT;
        endcase
      end
    end
  end

  // Frame-end pulse: strobe leaving the last visible pixel of the last visible line.
  assign animate_d = i_pix_stb && (h_cnt_q == H_ACT_END) && (v_cnt_q == V_ACT_END);

  // Outputs are decoded from the next-state values so they line up with the counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt_q   <= 10'd0;
      v_cnt_q   <= 10'd0;
      h_state_q <= HS_ACT;
      v_state_q <= VS_ACT;
      frame_q   <= 8'd0;
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
      x_q       <= 10'd0;
      y_q       <= 9'd0;
      active_q  <= 1'b1;
      animate_q <= 1'b0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
      frame_q   <= frame_d;
      hs_q      <= (h_state_d == HS_SYNC) ? SYNC_POL : ~SYNC_POL;
      vs_q      <= (v_state_d == VS_SYNC) ? SYNC_POL : ~SYNC_POL;
      x_q       <= (h_state_d == HS_ACT) ? h_cnt_d : 10'd0;
      y_q       <= (v_state_d == VS_ACT) ? v_cnt_d[8:0] : 9'd0;
      active_q  <= (h_state_d == HS_ACT) && (v_state_d == VS_ACT);
      animate_q <= animate_d;
    end
  end

  assign o_hs      = hs_q;
  assign o_vs      = vs_q;
  assign o_x       = x_q;
  assign o_y       = y_q;
  assign o_active  = active_q;
  assign o_animate = animate_q;
  assign o_frame   = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 640x480 instance for line timing, a shrunken-timing
// instance (15x10 totals) for frame, gap, mid-frame reset and frame-wrap behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_f, stb_f, hs_f, vs_f, act_f, anim_f;
  logic [9:0] x_f;
  logic [8:0] y_f;
  logic [7:0] frame_f;

  logic       rst_s, stb_s, hs_s, vs_s, act_s, anim_s;
  logic [9:0] x_s;
  logic [8:0] y_s;
  logic [7:0] frame_s;

  int checks = 0;
  int passed = 0;

  vga_timing_gen u_full (
    .i_clk(clk), .i_rst(rst_f), .i_pix_stb(stb_f),
    .o_hs(hs_f), .o_vs(vs_f), .o_x(x_f), .o_y(y_f),
    .o_active(act_f), .o_animate(anim_f), .o_frame(frame_f)
  );

  // Small timing: H 8/2/3/2 (total 15, hsync h=10..12), V 6/1/2/1 (total 10, vsync v=7..8).
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) u_small (
    .i_clk(clk), .i_rst(rst_s), .i_pix_stb(stb_s),
    .o_hs(hs_s), .o_vs(vs_s), .o_x(x_s), .o_y(y_s),
    .o_active(act_s), .o_animate(anim_s), .o_frame(frame_s)
  );

  // Expected {hs, active, x, y} of the full instance after k strobes (first two lines).
  function automatic logic [20:0] exp_f(input int k);
    int   h = k % 800;
    int   v = k / 800;
    logic hs  = !(h >= 656 && h <= 751);
    logic act = (h < 640) && (v < 480);
    int   x   = (h < 640) ? h : 0;
    return {hs, act, 10'(x), 9'(v)};
  endfunction

  // Expected {hs, vs, active, x, y, frame} of the small instance after k strobes.
  function automatic logic [29:0] exp_s(input int k);
    int   h = k % 15;
    int   v = (k / 15) % 10;
    int   f = (k / 150) % 256;
    logic hs  = !(h >= 10 && h <= 12);
    logic vs  = !(v >= 7 && v <= 8);
    logic act = (h < 8) && (v < 6);
    int   x   = (h < 8) ? h : 0;
    int   y   = (v < 6) ? v : 0;
    return {hs, vs, act, 10'(x), 9'(y), 8'(f)};
  endfunction

  function automatic logic [29:0] obs_s();
    return {hs_s, vs_s, act_s, x_s, y_s, frame_s};
  endfunction

  task automatic cyc_f(input logic rst, input logic stb);
    rst_f = rst;
    stb_f = stb;
    @(negedge clk);
  endtask

  task automatic cyc_s(input logic rst, input logic stb);
    rst_s = rst;
    stb_s = stb;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_f = 1'b1; stb_f = 1'b1;
    rst_s = 1'b1; stb_s = 1'b1;
    @(negedge clk);
    rst_f = 1'b0; stb_f = 1'b0;
    rst_s = 1'b0; stb_s = 1'b0;
    checks++; if (x_f !== 10'd0) $display("FAIL reset_x got=%0d exp=0", x_f); else passed++;
    checks++; if (y_f !== 9'd0) $display("FAIL reset_y got=%0d exp=0", y_f); else passed++;
    checks++; if (act_f !== 1'b1) $display("FAIL reset_active got=%b exp=1", act_f); else passed++;
    checks++; if (hs_f !== 1'b1) $display("FAIL reset_hs got=%b exp=1", hs_f); else passed++;
    checks++; if (vs_f !== 1'b1) $display("FAIL reset_vs got=%b exp=1", vs_f); else passed++;
    checks++; if (anim_f !== 1'b0) $display("FAIL reset_animate got=%b exp=0", anim_f); else passed++;
    checks++; if (frame_f !== 8'd0) $display("FAIL reset_frame got=%0d exp=0", frame_f); else passed++;
    checks++; if (obs_s() !== exp_s(0)) $display("FAIL reset_small got=%h exp=%h", obs_s(), exp_s(0)); else passed++;
    checks++; if (anim_s !== 1'b0) $display("FAIL reset_small_animate got=%b exp=0", anim_s); else passed++;
  endtask

  task automatic test_line();
    logic [20:0] got;
    cyc_f(1'b1, 1'b0);
    for (int k = 1; k <= 800; k++) begin
      cyc_f(1'b0, 1'b1);
      got = {hs_f, act_f, x_f, y_f};
      checks++; if (got !== exp_f(k)) $display("FAIL line_vec k=%0d got=%h exp=%h", k, got, exp_f(k)); else passed++;
      checks++; if (anim_f !== 1'b0) $display("FAIL line_animate k=%0d got=%b exp=0", k, anim_f); else passed++;
    end
    cyc_f(1'b0, 1'b0);
    checks++; if (y_f !== 9'd1) $display("FAIL line_end_y got=%0d exp=1", y_f); else passed++;
    checks++; if (x_f !== 10'd0) $display("FAIL line_end_x got=%0d exp=0", x_f); else passed++;
    checks++; if (hs_f !== 1'b1) $display("FAIL line_end_hs got=%b exp=1", hs_f); else passed++;
    checks++; if (vs_f !== 1'b1) $display("FAIL line_end_vs got=%b exp=1", vs_f); else passed++;
  endtask

  task automatic test_frame();
    int pulses = 0;
    int vs_low = 0;
    cyc_s(1'b1, 1'b0);
    for (int k = 1; k <= 150; k++) begin
      cyc_s(1'b0, 1'b1);
      if (anim_s === 1'b1) pulses++;
      if (vs_s === 1'b0) vs_low++;
      checks++; if (obs_s() !== exp_s(k)) $display("FAIL frame_vec k=%0d got=%h exp=%h", k, obs_s(), exp_s(k)); else passed++;
      checks++; if (anim_s !== (k == 83)) $display("FAIL frame_animate k=%0d got=%b exp=%b", k, anim_s, (k == 83)); else passed++;
    end
    stb_s = 1'b0;
    checks++; if (pulses !== 1) $display("FAIL frame_pulse_count got=%0d exp=1", pulses); else passed++;
    checks++; if (vs_low !== 30) $display("FAIL frame_vs_low got=%0d exp=30", vs_low); else passed++;
    checks++; if (frame_s !== 8'd1) $display("FAIL frame_count got=%0d exp=1", frame_s); else passed++;
  endtask

  task automatic test_gaps();
    cyc_s(1'b1, 1'b0);
    for (int k = 1; k <= 150; k++) begin
      cyc_s(1'b0, 1'b1);
      checks++; if ({anim_s, obs_s()} !== {(k == 83), exp_s(k)})
        $display("FAIL gap_strobe k=%0d got=%h exp=%h", k, {anim_s, obs_s()}, {(k == 83), exp_s(k)}); else passed++;
      for (int g = 0; g < 7; g++) begin
        cyc_s(1'b0, 1'b0);
        checks++; if ({anim_s, obs_s()} !== {1'b0, exp_s(k)})
          $display("FAIL gap_hold k=%0d g=%0d got=%h exp=%h", k, g, {anim_s, obs_s()}, {1'b0, exp_s(k)}); else passed++;
      end
    end
  endtask

  task automatic test_mid_reset();
    cyc_s(1'b1, 1'b0);
    for (int k = 1; k <= 183; k++) cyc_s(1'b0, 1'b1);
    checks++; if (obs_s() !== exp_s(183)) $display("FAIL midrst_pre got=%h exp=%h", obs_s(), exp_s(183)); else passed++;
    cyc_s(1'b1, 1'b1);
    checks++; if (x_s !== 10'd0) $display("FAIL midrst_x got=%0d exp=0", x_s); else passed++;
    checks++; if (y_s !== 9'd0) $display("FAIL midrst_y got=%0d exp=0", y_s); else passed++;
    checks++; if (frame_s !== 8'd0) $display("FAIL midrst_frame got=%0d exp=0", frame_s); else passed++;
    checks++; if ({hs_s, vs_s, act_s} !== 3'b111) $display("FAIL midrst_sync got=%b exp=111", {hs_s, vs_s, act_s}); else passed++;
    // Reset on the strobe that would raise the frame-end pulse.
    for (int k = 1; k <= 82; k++) cyc_s(1'b0, 1'b1);
    cyc_s(1'b1, 1'b1);
    checks++; if (anim_s !== 1'b0) $display("FAIL midrst_animate got=%b exp=0", anim_s); else passed++;
    checks++; if (obs_s() !== exp_s(0)) $display("FAIL midrst_state got=%h exp=%h", obs_s(), exp_s(0)); else passed++;
    cyc_s(1'b0, 1'b1);
    checks++; if (obs_s() !== exp_s(1)) $display("FAIL midrst_resume got=%h exp=%h", obs_s(), exp_s(1)); else passed++;
    stb_s = 1'b0;
  endtask

  task automatic test_wrap();
    int pulses = 0;
    cyc_s(1'b1, 1'b0);
    for (int k = 1; k <= 38400; k++) begin
      cyc_s(1'b0, 1'b1);
      if (anim_s === 1'b1) pulses++;
      if ((k % 150 == 0) || (k % 150 == 149)) begin
        checks++; if (frame_s !== 8'((k / 150) % 256))
          $display("FAIL wrap_frame k=%0d got=%0d exp=%0d", k, frame_s, (k / 150) % 256); else passed++;
      end
    end
    stb_s = 1'b0;
    checks++; if (pulses !== 256) $display("FAIL wrap_pulses got=%0d exp=256", pulses); else passed++;
    checks++; if (obs_s() !== exp_s(0)) $display("FAIL wrap_final got=%h exp=%h", obs_s(), exp_s(0)); else passed++;
  endtask

  initial begin
    rst_f = 1'b1; stb_f = 1'b0;
    rst_s = 1'b1; stb_s = 1'b0;
    @(negedge clk);
    test_reset();
    test_line();
    test_frame();
    test_gaps();
    test_mid_reset();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
